debug_scan_controller: RTL and testbench

//  Initiator side of the debug-mux interface. On a start pulse it sweeps the debug selector

---
 rtl/debug_scan_controller_if.sv | 21 ++
 rtl/debug_scan_controller.sv | 151 +++++++++++++++
 tb/tb_debug_scan_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_scan_controller_if.sv
// Debug-mux and byte-stream bundle between the scan controller (master) and its
// responder/host shim (slave).
interface debug_scan_controller_if;
  logic [7:0] debug_config_out;
  logic       debug_en;
  logic [7:0] debug_data_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output debug_config_out, debug_en, out_valid, out_data, out_last,
    input  debug_data_in, out_ready
  );

  modport slave (
    input  debug_config_out, debug_en, out_valid, out_data, out_last,
    output debug_data_in, out_ready
  );
endinterface

// File: rtl/debug_scan_controller.sv
// Sweeps the debug selector over all membrane slots plus the spike code, snapshots each word,
// then streams the snapshot. Optional XOR trailer byte under DEBUG_SCAN_CHECKSUM_EN.
module debug_scan_controller #(
  parameter int unsigned NUM_NEURONS   = 10,
  parameter logic [7:0]  SPIKE_SEL     = 8'hFF,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  debug_scan_controller_if.master bus,
  output logic                    busy,
  output logic                    done
);
  localparam int unsigned ENTRIES = NUM_NEURONS + 1;
`ifdef DEBUG_SCAN_CHECKSUM_EN
  localparam int unsigned STREAM_LEN = ENTRIES + 1;
`else
  localparam int unsigned STREAM_LEN = ENTRIES;
`endif
  localparam int unsigned IDX_W = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_ENTRY = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W-1:0] LAST_BYTE  = IDX_W'(STREAM_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, STREAM, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;
  logic [7:0]       snap_q [ENTRIES];

  logic [7:0]       cfg_d, data_d, byte_d;
  logic             en_d, valid_d, last_d, busy_d, done_d;
  logic [IDX_W-1:0] rd_idx;

  function automatic logic [7:0] selector(input logic [IDX_W-1:0] i);
    return (32'(i) < NUM_NEURONS) ? 8'(i) : SPIKE_SEL;
  endfunction

`ifdef DEBUG_SCAN_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of the words captured in the current scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'h00;
    end else if (state_q == IDLE && start) begin
      csum_q <= 8'h00;
    end else if (capture) begin
      csum_q <= csum_q ^ bus.debug_data_in;
    end
  end
`endif

  // Next-state, capture strobe and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    cfg_d   = bus.debug_config_out;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          capture = 1'b1;
          if (idx_q == LAST_ENTRY) begin
            state_d = STREAM;
            idx_d   = '0;
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STREAM: begin
        if (bus.out_valid && bus.out_ready) begin
          if (idx_q == LAST_BYTE) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state/index.
    en_d = (state_d == LOAD);
    if (state_d == LOAD) cfg_d = selector(idx_d);

    rd_idx = (idx_d > LAST_ENTRY) ? LAST_ENTRY : idx_d;
    byte_d = snap_q[rd_idx];
`ifdef DEBUG_SCAN_CHECKSUM_EN
    if (idx_d == LAST_BYTE) byte_d = csum_q;
`endif
    valid_d = (state_d == STREAM);
    data_d  = valid_d ? byte_d : 8'h00;
    last_d  = valid_d && (idx_d == LAST_BYTE);
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      idx_q                <= '0;
      cnt_q                <= '0;
      bus.debug_config_out <= 8'h00;
      bus.debug_en         <= 1'b0;
      bus.out_valid        <= 1'b0;
      bus.out_data         <= 8'h00;
      bus.out_last         <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      state_q              <= state_d;
      idx_q                <= idx_d;
      cnt_q                <= cnt_d;
      bus.debug_config_out <= cfg_d;
      bus.debug_en         <= en_d;
      bus.out_valid        <= valid_d;
      bus.out_data         <= data_d;
      bus.out_last         <= last_d;
      busy                 <= busy_d;
      done                 <= done_d;
    end
  end

  // Snapshot storage is deliberately not reset; stale entries are always rescanned first.
  always_ff @(posedge clk) begin
    if (capture) snap_q[idx_q[IDX_W-1:0] > LAST_ENTRY ? LAST_ENTRY : idx_q] <= bus.debug_data_in;
  end
endmodule

// File: tb/tb_debug_scan_controller.sv
// Directed bench for debug_scan_controller with a registered-config responder model.
// Build with +define+DEBUG_SCAN_CHECKSUM_EN to expect the XOR trailer byte.
module tb_debug_scan_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  debug_scan_controller_if bus();

  debug_scan_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

`ifdef DEBUG_SCAN_CHECKSUM_EN
  localparam int N_EXP = 12;
`else
  localparam int N_EXP = 11;
`endif
  logic [7:0] exp_bytes [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                 8'h07, 8'h08, 8'h09, 8'h0A, 8'hA5, 8'hAE};

  // Responder: config register loaded on debug_en; returns i+1 for slot i and A5 for spikes.
  logic [7:0]  resp_cfg = 8'h00;
  int unsigned cyc = 0;
  logic [7:0]  cfg_log [$];
  int unsigned load_cyc [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.debug_en) begin
      resp_cfg <= bus.debug_config_out;
      cfg_log.push_back(bus.debug_config_out);
      load_cyc.push_back(cyc);
    end
  end

  assign bus.debug_data_in = (resp_cfg == 8'hFF) ? 8'hA5 : resp_cfg + 8'd1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg"},   32'(bus.debug_config_out), 32'h0);
    check({tag, "_en"},    32'(bus.debug_en),         32'h0);
    check({tag, "_valid"}, 32'(bus.out_valid),        32'h0);
    check({tag, "_data"},  32'(bus.out_data),         32'h0);
    check({tag, "_last"},  32'(bus.out_last),         32'h0);
    check({tag, "_busy"},  32'(busy),                 32'h0);
    check({tag, "_done"},  32'(done),                 32'h0);
  endtask

  task automatic check_loads();
    int n;
    n = cfg_log.size();
    check("load_count", 32'(n), 32'd11);
    for (int i = 0; i < 11 && i < n; i++) begin
      check("load_sel", 32'(cfg_log[i]), (i < 10) ? 32'(i) : 32'hFF);
      if (i > 0) check("load_spacing", 32'(load_cyc[i] - load_cyc[i-1]), 32'd3);
    end
    cfg_log.delete();
    load_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Accepts the whole stream, optionally toggling ready each cycle; ends in the done cycle.
  task automatic collect_stream(input bit toggle);
    int got   = 0;
    int guard = 0;
    bit rdy   = 1'b1;
    bit stalled = 1'b0;
    while (got < N_EXP && guard < 400) begin
      @(negedge clk);
      guard++;
      bus.out_ready = rdy;
      if (stalled) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data",  32'(bus.out_data),  32'(exp_bytes[got]));
        check("stall_last",  32'(bus.out_last),  32'(got == N_EXP - 1));
        stalled = 1'b0;
      end
      if (bus.out_valid) begin
        if (rdy) begin
          check("byte", 32'(bus.out_data), 32'(exp_bytes[got]));
          check("last", 32'(bus.out_last), 32'(got == N_EXP - 1));
          got++;
        end else begin
          stalled = 1'b1;
        end
      end
      if (toggle) rdy = !rdy;
    end
    check("stream_complete", 32'(got), 32'(N_EXP));
    @(negedge clk);
    check("done_pulse", 32'(done),          32'd1);
    check("done_busy",  32'(busy),          32'd0);
    check("done_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    bus.out_ready = 1'b1;

    // Power-on reset
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic scan with first-byte latency
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("load_en",   32'(bus.debug_en),         32'd1);
    check("load_cfg0", 32'(bus.debug_config_out), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("first_byte_latency", 32'(lat), 32'd33);
    collect_stream(1'b0);
    check_loads();
    check("post_scan_cfg", 32'(bus.debug_config_out), 32'hFF);
    check("post_scan_en",  32'(bus.debug_en),         32'd0);
    @(negedge clk);
    check("done_fall", 32'(done), 32'd0);

    // Backpressure with ready toggling
    pulse_start();
    collect_stream(1'b1);
    check_loads();
    @(negedge clk);

    // Start pulses during WAIT and STREAM are ignored
    pulse_start();
    fork
      collect_stream(1'b0);
      begin
        repeat (2) @(negedge clk);
        pulse_start();
        repeat (36) @(negedge clk);
        pulse_start();
      end
    join
    check_loads();
    // In DONE cycle now: this start must be dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored_busy", 32'(busy), 32'd0);
    check("done_start_ignored_en",   32'(bus.debug_en), 32'd0);
    pulse_start();
    check("restart_busy", 32'(busy), 32'd1);
    collect_stream(1'b0);
    check_loads();
    @(negedge clk);

    // Asynchronous reset during WAIT of entry 4, then a clean rescan
    pulse_start();
    repeat (13) @(negedge clk);
    check("wait4_cfg", 32'(bus.debug_config_out), 32'd4);
    check("wait4_en",  32'(bus.debug_en),         32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cfg_log.delete();
    load_cyc.delete();
    @(negedge clk);
    pulse_start();
    collect_stream(1'b0);
    check_loads();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
